pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Sequencing controller for the 5-stage ARM pipeline. Drives the program counter enable, IF/ID enable and flush, and the control-unit mux select (bubble insertion into ID/EX) from decode-stage register usage, the ID/EX load indication, branch resolution and an external halt request. Owns post-reset warm-up, load-use stalls, branch flush sequencing and saturating hazard statistics.

## Interface
- INIT_CYCLES, 2: cycles after reset release with the front end frozen and bubbles issued (0 allowed)
- BRANCH_PENALTY, 1: IF/ID flush cycles per taken branch (1..15)
- CNT_W, 16: width of statistics counters
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- id_rn  in  4  Rn field of instruction in IF/ID
- id_rm  in  4  Rm field of instruction in IF/ID
- id_uses_rn  in  1  ID instruction reads Rn
- id_uses_rm  in  1  ID instruction reads Rm
- ex_rd  in  4  destination register of instruction in ID/EX
- ex_load  in  1  ID/EX holds a load (reg_write_enable & mem_to_reg_select)
- branch_taken  in  1  branch resolved taken in ID this cycle
- ext_stall  in  1  external halt request, level-sensitive
- cnt_clear  in  1  synchronous clear of statistics counters
- pc_enable  out  1  program counter update enable
- if_id_enable  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads all-zero NOP instead of fetched instruction
- nop_select  out  1  control-unit mux select, 1 = zero control word into ID/EX
- state  out  3  current FSM state encoding
- stall_cycles  out  CNT_W  saturating count of load-use and halt bubble cycles
- flush_events  out  CNT_W  saturating count of taken branches handled

## Operation
- States: INIT, RUN, HALT, FLUSH.
- Load-use hazard (combinational): ex_load && ex_rd != 4'd15 && ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd)).
- INIT: pc_enable=0, if_id_enable=0, if_id_flush=0, nop_select=1; down-counter from INIT_CYCLES; goes to RUN when counter reaches 0. With INIT_CYCLES=0, reset state is RUN.
- RUN, priority order:
  - ext_stall: freeze front end (pc_enable=0, if_id_enable=0, nop_select=1); go to HALT.
  - load-use: same freeze for this cycle only; stay in RUN; stall_cycles++.
  - branch_taken: pc_enable=1, if_id_enable=1, if_id_flush=1, nop_select=0; flush_events++; if BRANCH_PENALTY>1 go to FLUSH with counter = BRANCH_PENALTY-1.
  - otherwise: pc_enable=1, if_id_enable=1, if_id_flush=0, nop_select=0.
- HALT: freeze outputs as above; stall_cycles++ every cycle in HALT and on the entry cycle; returns to RUN the cycle after ext_stall deasserts; hazards re-evaluated in RUN.
- FLUSH: pc_enable=1, if_id_enable=1, if_id_flush=1, nop_select=0; decrement; to RUN when counter reaches 0. ext_stall, load-use and branch_taken ignored in FLUSH (flushed instruction is a NOP).
- Load-use and branch_taken together in RUN: stall wins, branch_taken not counted; branch re-evaluated next cycle as IF/ID holds.
- Counters saturate at all-ones; cnt_clear has priority over increment in the same cycle.

## Timing
- Async reset: all outputs immediately pc_enable=0, if_id_enable=0, if_id_flush=0, nop_select=1 (INIT_CYCLES>0) or RUN outputs (INIT_CYCLES=0), state=INIT/RUN, counters 0.
- Reset released mid-operation: resumes in INIT with full INIT_CYCLES count; mid-FLUSH or mid-HALT progress discarded.
- Hazard, branch and freeze outputs are Mealy: valid in the same cycle the inputs appear, take effect at the next rising edge. State and counters registered, 1-cycle update latency.
- Load-use costs exactly 1 bubble; taken branch costs BRANCH_PENALTY flushed slots.

## Structure
- Package pipeline_ctrl_pkg: state encoding constants (INIT=0, RUN=1, HALT=2, FLUSH=3), PC register index 4'd15, NOP instruction word 32'h0.
- Sub-module hazard_detect: pure combinational load-use compare, reusable by future forwarding unit.

## Test plan
- Reset low 3 cycles, release, INIT_CYCLES=2 -> nop_select=1, pc_enable=0 for 2 cycles, then pc_enable=1, state=RUN.
- ex_load=1, ex_rd=3, id_uses_rn=1, id_rn=3 for 1 cycle -> one cycle pc_enable=0, if_id_enable=0, nop_select=1; stall_cycles=1.
- ex_load=1, ex_rd=15, id_rn=15 -> no stall; ex_load=0 with matching regs -> no stall.
- branch_taken 1 cycle, BRANCH_PENALTY=3 -> if_id_flush=1 for 3 consecutive cycles, flush_events=1, back to RUN.
- ext_stall high 4 cycles -> freeze 4 cycles + return RUN next cycle, stall_cycles=4; load-use and branch_taken same cycle -> stall only, flush_events unchanged.
- Preload stall_cycles to saturate (drive 65540 load-use cycles) -> holds 16'hFFFF; cnt_clear with hazard same cycle -> 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and architectural constants for the pipeline controller
package pipeline_ctrl_pkg;
  typedef enum logic [2:0] {
    INIT  = 3'd0,
    RUN   = 3'd1,
    HALT  = 3'd2,
    FLUSH = 3'd3
  } state_t;
  localparam logic [3:0]  PC_IDX    = 4'd15;
  localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the decode operands and the ID/EX load destination
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [3:0] id_rn,
  input  logic [3:0] id_rm,
  input  logic       id_uses_rn,
  input  logic       id_uses_rm,
  input  logic [3:0] ex_rd,
  input  logic       ex_load,
  output logic       load_use
);
  // A load into the PC is a branch, not a data dependency, so it never stalls
  always_comb
    load_use = ex_load && ex_rd != PC_IDX &&
               ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: front-end sequencing (warm-up, load-use stall, branch flush, halt) with hazard statistics
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES    = 2,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [3:0]       ex_rd,
  input  logic             ex_load,
  input  logic             branch_taken,
  input  logic             ext_stall,
  input  logic             cnt_clear,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             nop_select,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  localparam int MX = INIT_CYCLES > BRANCH_PENALTY ? INIT_CYCLES : BRANCH_PENALTY;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] INIT_LD = CW'(INIT_CYCLES);
  localparam logic [CW-1:0] FL_LD = CW'(BRANCH_PENALTY - 1);
  localparam state_t RST_ST = INIT_CYCLES == 0 ? RUN : INIT;
  state_t st, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic load_use, active, frz, br, last;
  hazard_detect u_hazard (
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_uses_rn (id_uses_rn),
    .id_uses_rm (id_uses_rm),
    .ex_rd      (ex_rd),
    .ex_load    (ex_load),
    .load_use   (load_use)
  );
  // HALT decides exactly like RUN: while ext_stall holds it freezes, on release the held instruction is re-evaluated
  always_comb begin
    active       = st == RUN || st == HALT;
    frz          = active && (ext_stall || load_use);
    br           = active && !frz && branch_taken;
    last         = cnt <= CW'(1);
    pc_enable    = (active && !frz) || st == FLUSH;
    if_id_enable = pc_enable;
    if_id_flush  = br || st == FLUSH;
    nop_select   = !pc_enable;
    state        = st;
  end
  // Next state and warm-up/flush down-counter
  always_comb begin
    nxt = st == INIT  ? (last ? RUN : INIT) :
          st == FLUSH ? (last ? RUN : FLUSH) :
          active      ? (active && ext_stall ? HALT : (br && BRANCH_PENALTY > 1) ? FLUSH : RUN) :
                        INIT;
    cnt_nxt = br ? FL_LD :
              (st == INIT || st == FLUSH) && cnt != '0 ? cnt - CW'(1) :
              !active && st != INIT && st != FLUSH ? INIT_LD : cnt;
  end
  // Registered state and saturating statistics, clear beats increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st           <= RST_ST;
      cnt          <= INIT_LD;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      st           <= nxt;
      cnt          <= cnt_nxt;
      stall_cycles <= cnt_clear ? '0 : (frz && stall_cycles != '1) ? stall_cycles + 1'b1 : stall_cycles;
      flush_events <= cnt_clear ? '0 : (br && flush_events != '1) ? flush_events + 1'b1 : flush_events;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors with hand-computed expectations for pipeline_ctrl
module tb_pipeline_ctrl;
  logic clk = 0, reset = 0;
  logic [3:0] id_rn = 0, id_rm = 0, ex_rd = 0;
  logic id_uses_rn = 0, id_uses_rm = 0, ex_load = 0, branch_taken = 0, ext_stall = 0, cnt_clear = 0;
  logic pc_enable, if_id_enable, if_id_flush, nop_select;
  logic [2:0] state;
  logic [15:0] stall_cycles, flush_events;
  int n_chk = 0, n_ok = 0;

  pipeline_ctrl #(.INIT_CYCLES(2), .BRANCH_PENALTY(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd), .ex_load(ex_load),
    .branch_taken(branch_taken), .ext_stall(ext_stall), .cnt_clear(cnt_clear),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .nop_select(nop_select), .state(state), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, {pc_enable, if_id_enable, if_id_flush, nop_select}, exp);
  endtask

  task automatic idle();
    {id_uses_rn, id_uses_rm, ex_load, branch_taken, ext_stall, cnt_clear} = '0;
    id_rn = 0; id_rm = 0; ex_rd = 0;
  endtask

  task automatic lu();
    ex_load = 1; ex_rd = 4'd3; id_uses_rn = 1; id_rn = 4'd3;
  endtask

  initial begin
    repeat (3) cyc();
    outs("reset_outs", 4'b0001);
    chk("reset_state", state, 0);
    chk("reset_cnt", {stall_cycles, flush_events}, 0);
    reset = 1;
    outs("init1", 4'b0001);
    chk("init1_state", state, 0);
    cyc();
    outs("init2", 4'b0001);
    cyc();
    outs("run_outs", 4'b1100);
    chk("run_state", state, 1);
    lu();
    outs("lu_freeze", 4'b0001);
    cyc();
    idle();
    outs("lu_after", 4'b1100);
    chk("lu_stall_cnt", stall_cycles, 1);
    ex_load = 1; ex_rd = 4'd15; id_uses_rn = 1; id_rn = 4'd15;
    outs("pc_load_no_stall", 4'b1100);
    ex_load = 0; ex_rd = 4'd3; id_rn = 4'd3;
    outs("no_load_no_stall", 4'b1100);
    idle();
    ex_load = 1; ex_rd = 4'd5; id_uses_rm = 1; id_rm = 4'd5;
    outs("rm_stall", 4'b0001);
    id_uses_rm = 0;
    outs("rm_unused", 4'b1100);
    idle();
    branch_taken = 1;
    outs("br_cycle1", 4'b1110);
    cyc();
    idle();
    outs("br_cycle2", 4'b1110);
    chk("br_state_flush", state, 3);
    chk("br_events", flush_events, 1);
    cyc();
    outs("br_cycle3", 4'b1110);
    cyc();
    outs("br_done", 4'b1100);
    chk("br_back_run", state, 1);
    ext_stall = 1;
    outs("halt_entry", 4'b0001);
    repeat (3) begin
      cyc();
      outs("halt_hold", 4'b0001);
    end
    cyc();
    ext_stall = 0;
    chk("halt_state", state, 2);
    chk("halt_stall_cnt", stall_cycles, 5);
    outs("halt_release", 4'b1100);
    cyc();
    chk("halt_back_run", state, 1);
    lu();
    branch_taken = 1;
    outs("lu_br_stall", 4'b0001);
    cyc();
    idle();
    chk("lu_br_events", flush_events, 1);
    chk("lu_br_stall_cnt", stall_cycles, 6);
    chk("lu_br_state", state, 1);
    branch_taken = 1;
    cyc();
    branch_taken = 0;
    lu();
    ext_stall = 1;
    outs("flush_ignores", 4'b1110);
    chk("flush_ign_state", state, 3);
    cyc();
    cyc();
    idle();
    chk("flush_ign_run", state, 1);
    chk("flush_ign_stall", stall_cycles, 6);
    chk("flush_ign_events", flush_events, 2);
    lu();
    repeat (65540) cyc();
    chk("stall_saturate", stall_cycles, 16'hFFFF);
    cnt_clear = 1;
    cyc();
    chk("clear_beats_inc", stall_cycles, 0);
    chk("clear_events", flush_events, 0);
    cnt_clear = 0;
    cyc();
    chk("count_after_clear", stall_cycles, 1);
    idle();
    branch_taken = 1;
    cyc();
    idle();
    chk("pre_reset_flush", state, 3);
    reset = 0;
    outs("async_reset_outs", 4'b0001);
    chk("async_reset_state", state, 0);
    chk("async_reset_cnt", {stall_cycles, flush_events}, 0);
    cyc();
    reset = 1;
    outs("reinit1", 4'b0001);
    cyc();
    outs("reinit2", 4'b0001);
    cyc();
    outs("rerun", 4'b1100);
    chk("rerun_state", state, 1);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
